// File: rtl/sha256_stream_core.sv
`timescale 1ns/1ps
// Purpose: SHA-256 compression of pre-padded 512-bit blocks, chaining H across the blocks of one message.
// Latency: accept on edge 0, rounds on edges 1..N (N = 64/ROUNDS_PER_CYCLE), H update on edge N+1, digest valid after it.
// Backpressure: in_ready only in IDLE; digest held until out_ready; clear aborts any block and restores the standard IV.
module sha256_stream_core #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit IV_LOAD_EN       = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   input  logic         in_last,
   input  logic         in_iv_sel,
   input  logic [255:0] in_iv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_hash
);
   localparam int         R        = ROUNDS_PER_CYCLE;
   localparam logic [6:0] LAST_CNT = 7'(64 - R);

   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_UPDATE, ST_OUTPUT} state_e;

   generate
      if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
         $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction
   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   state_e      state_q, state_d;
   logic [31:0] h_q  [8],  h_d  [8];   // chaining value H0..H7
   logic [31:0] wk_q [8],  wk_d [8];   // working registers a..h
   logic [31:0] w_q  [16], w_d  [16];  // schedule window, w_q[0] is W[t]
   logic        last_q, last_d;
   logic [6:0]  cnt_q, cnt_d;          // round index t of the current cycle

   logic [31:0] ext [16+R];            // window extended by the R words that shift in
   logic [31:0] rnd [8];               // a..h after this cycle's R rounds
   logic [31:0] t1, t2;
   logic [5:0]  kidx;

   // Round datapath: R chained rounds plus the schedule words that refill the window tail.
   always_comb begin
      for (int i = 0; i < 16; i++) ext[i] = w_q[i];
      for (int i = 16; i < 16 + R; i++)
         ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
      for (int i = 0; i < 8; i++) rnd[i] = wk_q[i];
      t1   = '0;
      t2   = '0;
      kidx = '0;
      for (int r = 0; r < R; r++) begin
         kidx   = cnt_q[5:0] + 6'(r);
         t1     = rnd[7] + bsig1(rnd[4]) + ((rnd[4] & rnd[5]) ^ (~rnd[4] & rnd[6])) + K[kidx] + ext[r];
         t2     = bsig0(rnd[0]) + ((rnd[0] & rnd[1]) ^ (rnd[0] & rnd[2]) ^ (rnd[1] & rnd[2]));
         rnd[7] = rnd[6];
         rnd[6] = rnd[5];
         rnd[5] = rnd[4];
         rnd[4] = rnd[3] + t1;
         rnd[3] = rnd[2];
         rnd[2] = rnd[1];
         rnd[1] = rnd[0];
         rnd[0] = t1 + t2;
      end
   end

   // Control: next state, register updates and handshake outputs; clear overrides everything.
   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      wk_d      = wk_q;
      w_d       = w_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_hash  = '0;
      if (clear) begin
         state_d = ST_IDLE;
         h_d     = IV;
      end else begin
         case (state_q)
            ST_IDLE: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  // Start value: midstate, standard IV, or the chain carried from the previous block.
                  for (int i = 0; i < 8; i++) begin
                     if (in_first && in_iv_sel && IV_LOAD_EN) h_d[i] = in_iv[255-32*i -: 32];
                     else if (in_first)                       h_d[i] = IV[i];
                  end
                  wk_d = h_d;
                  for (int i = 0; i < 16; i++) w_d[i] = in_block[511-32*i -: 32];
                  last_d  = in_last;
                  cnt_d   = '0;
                  state_d = ST_ROUND;
               end
            end
            ST_ROUND: begin
               wk_d = rnd;
               for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];
               cnt_d = cnt_q + 7'(R);
               if (cnt_q == LAST_CNT) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
               for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wk_q[i];
               state_d = last_q ? ST_OUTPUT : ST_IDLE;
            end
            ST_OUTPUT: begin
               out_valid = 1'b1;
               for (int i = 0; i < 8; i++) out_hash[255-32*i -: 32] = h_q[i];
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers; reset drops any block in flight and restores the standard IV.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < 8; i++) begin
            h_q[i]  <= IV[i];
            wk_q[i] <= '0;
         end
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         wk_q    <= wk_d;
         w_q     <= w_d;
      end
   end
endmodule

// File: tb/tb_sha256_stream_core.sv
`timescale 1ns/1ps
// Bench for sha256_stream_core: three instances (1, 2 and 4 rounds per clock), known-answer vectors,
// handshake/latency, backpressure, clear and reset cases, then random multi-block messages against a
// plain SHA-256 reference that expands the full 64-word schedule.
module tb_sha256_stream_core;
   localparam int ND = 3;

   localparam logic [255:0] IVC   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear     [ND];
   logic         in_valid  [ND];
   logic         in_ready  [ND];
   logic [511:0] in_block  [ND];
   logic         in_first  [ND];
   logic         in_last   [ND];
   logic         in_iv_sel [ND];
   logic [255:0] in_iv     [ND];
   logic         out_valid [ND];
   logic         out_ready [ND];
   logic [255:0] out_hash  [ND];

   logic [255:0] mh [ND];   // reference chaining value per instance
   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   // Instance d runs 1<<d rounds per clock; instance 1 has the midstate load disabled.
   for (genvar g = 0; g < ND; g++) begin : g_dut
      sha256_stream_core #(.ROUNDS_PER_CYCLE(1 << g), .IV_LOAD_EN(g != 1)) u_dut (
         .clk(clk), .rst_n(rst_n), .clear(clear[g]),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_block(in_block[g]),
         .in_first(in_first[g]), .in_last(in_last[g]), .in_iv_sel(in_iv_sel[g]), .in_iv(in_iv[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_hash(out_hash[g]));
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference compression: full 64-word message schedule, then 64 rounds, then feed-forward.
   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  v [8];
      logic [31:0]  s0, s1, t1, t2;
      logic [255:0] res;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
         t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
         t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return res;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Offer a block at a negedge and hold it until accepted; returns just after the accept edge.
   task automatic send(input int d, input logic [511:0] blk, input logic f, input logic l,
                       input logic s, input logic [255:0] iv, input string tag);
      int n = 0;
      @(negedge clk);
      in_valid[d] = 1'b1; in_block[d] = blk; in_first[d] = f;
      in_last[d] = l; in_iv_sel[d] = s; in_iv[d] = iv;
      while (!in_ready[d] && n < 300) begin @(negedge clk); n++; end
      check({tag, "_accept"}, 256'(in_ready[d]), 256'(1));
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
   endtask

   // Digest arrives N+1 edges after accept; with out_ready high it lasts exactly one cycle.
   task automatic wait_digest(input int d, input logic [255:0] exp, input string tag);
      int lat = 0;
      @(negedge clk);
      while (!out_valid[d] && lat < 300) begin @(negedge clk); lat++; end
      check({tag, "_lat"}, 256'(lat), 256'((64 >> d) + 1));
      check({tag, "_hash"}, out_hash[d], exp);
      if (out_ready[d]) begin
         @(negedge clk);
         check({tag, "_done"}, 256'({out_valid[d], in_ready[d]}), 256'(2'b01));
      end
   endtask

   // Non-last block: back to ready N+1 edges after accept, never raising out_valid.
   task automatic wait_chain(input int d, input string tag);
      int   lat = 0;
      logic saw = 1'b0;
      @(negedge clk);
      while (!in_ready[d] && lat < 300) begin
         saw |= out_valid[d];
         @(negedge clk); lat++;
      end
      saw |= out_valid[d];
      check({tag, "_lat"}, 256'(lat), 256'((64 >> d) + 1));
      check({tag, "_novld"}, 256'(saw), 256'(0));
   endtask

   task automatic run_block(input int d, input logic [511:0] blk, input logic f, input logic l,
                            input logic s, input logic [255:0] iv, input logic kat,
                            input logic [255:0] kat_val, input string tag);
      logic [255:0] start;
      start = f ? ((s && d != 1) ? iv : IVC) : mh[d];
      mh[d] = compress(start, blk);
      send(d, blk, f, l, s, iv, tag);
      if (l) wait_digest(d, kat ? kat_val : mh[d], tag);
      else   wait_chain(d, tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] abc_blk, empty_blk, two_b1, two_b2, blk;
      logic [255:0] mid, ivr;
      logic         flag;
      int           n, nblk;

      abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
      empty_blk = {32'h80000000, 480'h0};
      two_b1    = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
      two_b2    = 512'h1c0;

      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         clear[d] = 1'b0; in_valid[d] = 1'b0; in_block[d] = '0; in_first[d] = 1'b0;
         in_last[d] = 1'b0; in_iv_sel[d] = 1'b0; in_iv[d] = '0; out_ready[d] = 1'b1;
         mh[d] = IVC;
      end

      // Reset state
      #12;
      check("rst_vld", 256'(out_valid[0]), 256'(0));
      check("rst_hash", out_hash[0], 256'(0));
      @(negedge clk); rst_n = 1'b1; #1;
      for (int d = 0; d < ND; d++) check($sformatf("rst_rdy%0d", d), 256'(in_ready[d]), 256'(1));

      // Known-answer vectors at each unroll factor; instance 1 must ignore the junk midstate
      run_block(0, abc_blk, 1'b1, 1'b1, 1'b0, '0, 1'b1, ABC, "abc_r1");
      run_block(1, empty_blk, 1'b1, 1'b1, 1'b1, rand256(), 1'b1, EMPTY, "empty_r2");
      run_block(2, empty_blk, 1'b1, 1'b1, 1'b0, '0, 1'b1, EMPTY, "empty_r4");

      // Two-block message, chained
      run_block(0, two_b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "two_b1");
      run_block(0, two_b2, 1'b0, 1'b1, 1'b0, '0, 1'b1, TWO, "two_b2");

      // Midstate: second block restarted from the H value left by block 1
      mid = compress(IVC, two_b1);
      run_block(0, two_b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "mid_b1");
      run_block(0, two_b2, 1'b1, 1'b1, 1'b1, mid, 1'b1, TWO, "mid_b2");

      // Backpressure with junk offered throughout ROUND and OUTPUT
      out_ready[0] = 1'b0;
      send(0, abc_blk, 1'b1, 1'b1, 1'b0, '0, "bp");
      flag = 1'b0; n = 0;
      in_valid[0] = 1'b1; in_block[0] = rand512(); in_first[0] = 1'b1;
      while (!out_valid[0] && n < 300) begin
         @(negedge clk);
         flag |= in_ready[0];
         in_block[0] = rand512(); in_first[0] = 1'($urandom); n++;
      end
      check("bp_busy_rdy", 256'(flag), 256'(0));
      for (int i = 0; i < 20; i++) begin
         check("bp_hold_hash", out_hash[0], ABC);
         check("bp_hold_rdy", 256'({out_valid[0], in_ready[0]}), 256'(2'b10));
         @(negedge clk);
         in_block[0] = rand512();
      end
      in_valid[0] = 1'b0; out_ready[0] = 1'b1;
      @(negedge clk);
      check("bp_release", 256'({out_valid[0], in_ready[0]}), 256'(2'b01));
      mh[0] = IVC;
      run_block(0, rand512(), 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, "bp_next");

      // clear at round 30 of a midstate block, then "abc" chained from the restored IV
      send(0, rand512(), 1'b1, 1'b1, 1'b1, rand256(), "clr_blk");
      repeat (30) @(posedge clk);
      @(negedge clk);
      clear[0] = 1'b1; in_valid[0] = 1'b1; in_block[0] = rand512(); in_first[0] = 1'b1;
      #1;
      check("clr_round", 256'({out_valid[0], in_ready[0]}), 256'(2'b00));
      @(negedge clk);
      check("clr_idle_rdy", 256'(in_ready[0]), 256'(0));
      @(posedge clk); #1;
      clear[0] = 1'b0; in_valid[0] = 1'b0;
      @(negedge clk);
      check("clr_no_accept", 256'({out_valid[0], in_ready[0]}), 256'(2'b01));
      mh[0] = IVC;
      run_block(0, abc_blk, 1'b0, 1'b1, 1'b0, '0, 1'b1, ABC, "clr_abc");

      // Reset while a digest is held
      out_ready[0] = 1'b0;
      run_block(0, abc_blk, 1'b1, 1'b1, 1'b0, '0, 1'b1, ABC, "rsto");
      #2 rst_n = 1'b0;
      #1;
      check("rsto_vld", 256'(out_valid[0]), 256'(0));
      check("rsto_hash", out_hash[0], 256'(0));
      @(negedge clk); rst_n = 1'b1; out_ready[0] = 1'b1;

      // Reset at round 10; nothing may emerge, and first=0 chains from the IV
      send(0, rand512(), 1'b1, 1'b1, 1'b0, '0, "rst10");
      repeat (10) @(posedge clk);
      #3;
      check("rst10_pre_rdy", 256'(in_ready[0]), 256'(0));
      rst_n = 1'b0;
      #1;
      check("rst10_async", 256'({in_ready[0], out_valid[0], out_hash[0]}), 256'({1'b1, 1'b0, 256'h0}));
      @(negedge clk); rst_n = 1'b1;
      for (int d = 0; d < ND; d++) mh[d] = IVC;
      flag = 1'b0;
      repeat (80) begin @(negedge clk); flag |= out_valid[0]; end
      check("rst10_novld", 256'(flag), 256'(0));
      run_block(0, abc_blk, 1'b0, 1'b1, 1'b0, '0, 1'b1, ABC, "rst_abc");

      // Random multi-block messages against the reference
      for (int d = 0; d < ND; d++) begin
         for (int m = 0; m < 4; m++) begin
            nblk = $urandom_range(3, 1);
            for (int b = 0; b < nblk; b++) begin
               blk = rand512(); ivr = rand256();
               run_block(d, blk, b == 0, b == nblk - 1, 1'($urandom), ivr, 1'b0, '0,
                         $sformatf("rnd_d%0d_m%0d_b%0d", d, m, b));
            end
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
